boolean_lut_seq: RTL and testbench

//  Parametrised, registered truth-table evaluator. It generalises the fixed 3-input Boolean F(A,B,C) to N_IN inputs and N_OUT channels.
//  The truth table is loaded serially at run time. Input vectors are then evaluated under a valid/ready handshake, with registered outputs.
//  It sits between stimulus logic and checkers in the basic-logic lab designs.

---
 rtl/boolean_lut_seq.sv | 153 +++++++++++++++
 tb/tb_boolean_lut_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/boolean_lut_seq.sv
// Registered N_IN-input, N_OUT-channel truth-table evaluator with a serial table load port.
// Optional self-check ports (exp_vec, mismatch, err_count) are built when LUT_SELF_CHECK_EN is defined.
module boolean_lut_seq #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic             load_bit,
    output logic             load_done,
    output logic             tbl_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_vec
`ifdef LUT_SELF_CHECK_EN
    ,
    input  logic [N_OUT-1:0] exp_vec,
    output logic             mismatch,
    output logic [15:0]      err_count
`endif
);

    localparam int ENTRIES = 2 ** N_IN;
    localparam int DEPTH   = N_OUT * ENTRIES;
    localparam int CW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              wr_en;
    logic              load_done_next;
    logic [DEPTH-1:0]  table_reg;
    logic [N_OUT-1:0]  lut_vec;
    logic              accept;
    logic              out_valid_reg;
    logic [N_OUT-1:0]  out_vec_reg;

    assign accept    = in_valid && (state_reg == READY);
    assign in_ready  = (state_reg == READY);
    assign tbl_ready = (state_reg == READY);
    assign load_done = load_done_next;
    assign out_valid = out_valid_reg;
    assign out_vec   = out_vec_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // load_start wins over everything, so a coincident load_valid is dropped.
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        wr_en          = 1'b0;
        load_done_next = 1'b0;
        if (load_start) begin
            state_next = LOAD;
            count_next = '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (load_valid) begin
                        wr_en = 1'b1;
                        if (count_reg == LAST) begin
                            state_next     = READY;
                            load_done_next = !reset;
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
    end

    // One flop per table bit, written only at its own linear index.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    table_reg[gi] <= 1'b0;
                end else if (wr_en && (count_reg == CW'(gi))) begin
                    table_reg[gi] <= load_bit;
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
            logic [ENTRIES-1:0] chan_bits;
            assign chan_bits   = table_reg[gi*ENTRIES +: ENTRIES];
            assign lut_vec[gi] = chan_bits[in_vec];
        end
    endgenerate

    // The lookup uses the table as it stands before this edge, so an eval
    // coinciding with load_start still sees the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_vec_reg   <= '0;
        end else begin
            out_valid_reg <= accept;
            if (accept) begin
                out_vec_reg <= lut_vec;
            end
        end
    end

`ifdef LUT_SELF_CHECK_EN
    logic [N_OUT-1:0] exp_reg;
    logic [15:0]      err_count_reg;

    assign mismatch  = out_valid_reg && (|(out_vec_reg ^ exp_reg));
    assign err_count = err_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_reg       <= '0;
            err_count_reg <= '0;
        end else begin
            if (accept) begin
                exp_reg <= exp_vec;
            end
            if (mismatch && (err_count_reg != 16'hFFFF)) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_boolean_lut_seq.sv
// Scoreboard bench for boolean_lut_seq (N_IN=3, N_OUT=1): expected results are queued at
// drive time and popped whenever out_valid is seen.
module tb_boolean_lut_seq;

    logic       clk;
    logic       reset;
    logic       load_start;
    logic       load_valid;
    logic       load_bit;
    logic       load_done;
    logic       tbl_ready;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_vec;
    logic       out_valid;
    logic [0:0] out_vec;
`ifdef LUT_SELF_CHECK_EN
    logic [0:0] exp_vec;
    logic       mismatch;
    logic [15:0] err_count;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    logic q[$];
    logic [7:0] model_tbl;
    bit   model_ready;

    boolean_lut_seq #(.N_IN(3), .N_OUT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_bit   (load_bit),
        .load_done  (load_done),
        .tbl_ready  (tbl_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_vec    (out_vec)
`ifdef LUT_SELF_CHECK_EN
        ,
        .exp_vec    (exp_vec),
        .mismatch   (mismatch),
        .err_count  (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", tag, got, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                logic e;
                e = q.pop_front();
                check("out_vec", 32'(out_vec), 32'(e));
            end
        end
    end

    // Pulse load_start (with a decoy load_valid that must be ignored), then stream nbits.
    task automatic do_load(input logic [7:0] bits, input int nbits);
        load_start  = 1'b1;
        load_valid  = 1'b1;
        load_bit    = ~bits[0];
        model_ready = 1'b0;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            load_valid = 1'b1;
            load_bit   = bits[i];
            #1;
            check("load_done", 32'(load_done), 32'(i == 7));
            model_tbl[i] = bits[i];
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        if (nbits == 8) model_ready = 1'b1;
        check("tbl_ready", 32'(tbl_ready), 32'(nbits == 8));
        check("in_ready", 32'(in_ready), 32'(nbits == 8));
    endtask

    task automatic eval_one(input logic [2:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        if (model_ready) q.push_back(model_tbl[v]);
        tick();
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
        in_valid = 1'b0; in_vec = '0; model_tbl = '0; model_ready = 1'b0;
`ifdef LUT_SELF_CHECK_EN
        exp_vec = '0;
`endif
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_vec", 32'(out_vec), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_tbl_ready", 32'(tbl_ready), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;

        // Eval while EMPTY is dropped; the monitor flags any out_valid.
        eval_one(3'b101);
        eval_one(3'b101);
        in_valid = 1'b0;
        tick();

        // Test 2 table: only entry 5 set.
        do_load(8'b0010_0000, 8);
        eval_one(3'b101);
        eval_one(3'b100);
        in_valid = 1'b0;
        tick();
        tick();
        check("out_vec_hold", 32'(out_vec), 32'd0);
        check("out_valid_idle", 32'(out_valid), 32'd0);

        // load_valid in READY is ignored: entry 0 stays 0.
        load_valid = 1'b1; load_bit = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int v = 0; v < 8; v++) eval_one(3'(v));
        in_valid = 1'b0;
        tick();

        // Restart after 3 bits, then full reload of all ones.
        do_load(8'hFF, 3);
        do_load(8'hFF, 8);
        for (int v = 7; v >= 0; v--) eval_one(3'(v));
        in_valid = 1'b0;
        tick();

        // Eval coinciding with load_start uses the old table, then the port closes.
        in_valid = 1'b1; in_vec = 3'b010; load_start = 1'b1;
        q.push_back(model_tbl[2]);
        model_ready = 1'b0;
        tick();
        load_start = 1'b0;
        eval_one(3'b011);
        in_valid = 1'b0;
        check("tbl_ready_after_start", 32'(tbl_ready), 32'd0);
        do_load(8'b1001_0110, 8);
        for (int v = 0; v < 8; v++) eval_one(3'(v));
        in_valid = 1'b0;
        tick();

        // Reset mid-load clears the table and readiness.
        do_load(8'h0F, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_tbl = '0;
        model_ready = 1'b0;
        check("midload_rst_tbl_ready", 32'(tbl_ready), 32'd0);
        check("midload_rst_out_vec", 32'(out_vec), 32'd0);
        eval_one(3'b001);
        in_valid = 1'b0;
        do_load(8'b0110_1001, 8);
        for (int v = 0; v < 8; v++) eval_one(3'(v));
        in_valid = 1'b0;
        tick();

`ifdef LUT_SELF_CHECK_EN
        do_load(8'b0010_0000, 8);
        exp_vec = 1'b0;
        eval_one(3'b101);
        in_valid = 1'b0;
        check("mismatch_hit", 32'(mismatch), 32'd1);
        tick();
        check("err_count_1", 32'(err_count), 32'd1);
        exp_vec = 1'b1;
        eval_one(3'b101);
        in_valid = 1'b0;
        check("mismatch_clear", 32'(mismatch), 32'd0);
        tick();
        check("err_count_hold", 32'(err_count), 32'd1);
`endif

        tick();
        tick();
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
